// File: rtl/pm_tick_scheduler.sv
// -----------------------------------------------------------------------------
// pm_tick_scheduler
//
// Grants one frame slot at a time to N_PORTS requesters. Each grant is paid
// for with one frame credit. Credits are earned from a pacing tick, and ticks
// that arrive while the credit counter is full are tallied as drops. The owner
// is picked round-robin. A grant is held until the owner pulses done, or until
// TIMEOUT cycles have passed, whichever comes first.
//
// Ports
//   clk          : sole clock, rising edge
//   rst_n        : asynchronous active-low reset
//   enable       : when low, no new grant is issued (credits still accrue)
//   tick         : single-cycle pacing pulse, one frame credit each
//   req          : per-port level request
//   done         : per-port pulse ending the granted frame
//   grant        : registered one-hot (or zero) current owner
//   credits      : current credit count, saturates at MAX_CREDITS
//   drop_count   : ticks lost to saturation, saturates at 0xFFFF
//   timeout_err  : single-cycle pulse when a grant is aborted by timeout
// -----------------------------------------------------------------------------
module pm_tick_scheduler #(
   parameter int N_PORTS     = 4,
   parameter int MAX_CREDITS = 8,
   parameter int TIMEOUT     = 1024
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               enable,
   input  logic                               tick,
   input  logic [N_PORTS-1:0]                 req,
   input  logic [N_PORTS-1:0]                 done,
   output logic [N_PORTS-1:0]                 grant,
   output logic [$clog2(MAX_CREDITS+1)-1:0]   credits,
   output logic [15:0]                        drop_count,
   output logic                               timeout_err
);

   localparam int CW = $clog2(MAX_CREDITS + 1);
   localparam int PW = $clog2(N_PORTS);
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [CW-1:0] C_MAX   = CW'(MAX_CREDITS);
   localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT - 1);
   localparam logic [PW-1:0] P_LAST  = PW'(N_PORTS - 1);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]          r_state;
   logic [N_PORTS-1:0]  r_grant;
   logic [PW-1:0]       r_ptr;
   logic [TW-1:0]       r_timer;
   logic [CW-1:0]       r_credits;
   logic [15:0]         r_drop;
   logic                r_timeout_err;

   logic                w_found;
   logic [PW-1:0]       w_win_idx;
   logic [PW-1:0]       w_ptr_nxt;
   logic [N_PORTS-1:0]  w_win_onehot;
   logic                w_issue;
   logic                w_owner_done;
   logic                w_timeout;

   // Round-robin search: first asserted req at or after r_ptr, wrapping.
   always_comb begin
      int v_idx;
      w_found   = 1'b0;
      w_win_idx = '0;
      v_idx     = 0;
      for (int i = 0; i < N_PORTS; i++) begin
         v_idx = (int'(r_ptr) + i) % N_PORTS;
         if (!w_found && req[v_idx]) begin
            w_found   = 1'b1;
            w_win_idx = PW'(v_idx);
         end else begin
            w_found   = w_found;
         end
      end
   end

   // Grant issue, release and timeout decode.
   always_comb begin
      w_issue      = (r_state == S_IDLE) && enable && w_found &&
                     ((r_credits != '0) || tick);
      w_win_onehot = {{(N_PORTS-1){1'b0}}, 1'b1} << w_win_idx;
      if (w_win_idx == P_LAST) begin
         w_ptr_nxt = '0;
      end else begin
         w_ptr_nxt = w_win_idx + PW'(1);
      end
      // done on the expiring edge wins over the timeout
      w_owner_done = (r_state == S_BUSY) && (|(done & r_grant));
      w_timeout    = (r_state == S_BUSY) && !w_owner_done && (r_timer == T_LAST);
   end

   // Ownership state machine: grant, pointer, busy timer, timeout pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_grant       <= '0;
         r_ptr         <= '0;
         r_timer       <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_timeout_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_issue) begin
                  r_state <= S_BUSY;
                  r_grant <= w_win_onehot;
                  r_ptr   <= w_ptr_nxt;
                  r_timer <= '0;
               end
            end
            S_BUSY: begin
               if (w_owner_done) begin
                  r_state <= S_IDLE;
                  r_grant <= '0;
               end else if (w_timeout) begin
                  r_state       <= S_IDLE;
                  r_grant       <= '0;
                  r_timeout_err <= 1'b1;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_grant <= '0;
               r_timer <= '0;
            end
         endcase
      end
   end

   // Credit accounting; a tick landing with a grant issue cancels the spend.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_credits <= '0;
         r_drop    <= 16'd0;
      end else begin
         if (w_issue && tick) begin
            r_credits <= r_credits;
         end else if (w_issue) begin
            r_credits <= r_credits - CW'(1);
         end else if (tick) begin
            if (r_credits == C_MAX) begin
               if (r_drop != 16'hFFFF) begin
                  r_drop <= r_drop + 16'd1;
               end
            end else begin
               r_credits <= r_credits + CW'(1);
            end
         end
      end
   end

   assign grant       = r_grant;
   assign credits     = r_credits;
   assign drop_count  = r_drop;
   assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_pm_tick_scheduler.sv
module tb_pm_tick_scheduler;

   localparam int NP = 4;
   localparam int MC = 8;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          tick;
   logic [NP-1:0] req;
   logic [NP-1:0] done;
   logic [NP-1:0] grant;
   logic [3:0]    credits;
   logic [15:0]   drop_count;
   logic          timeout_err;

   int n_vec = 0;
   int n_err = 0;

   pm_tick_scheduler #(.N_PORTS(NP), .MAX_CREDITS(MC), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .tick(tick), .req(req),
      .done(done), .grant(grant), .credits(credits), .drop_count(drop_count),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        tk;
      logic [3:0]  rq;
      logic [3:0]  dn;
      logic [3:0]  g;
      logic [3:0]  cr;
      logic [15:0] dr;
      logic        te;
   } vec_t;

   vec_t vt[22];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      enable = 1'b0; tick = 1'b0; req = '0; done = '0;
      rst_n = 1'b0;
      cyc();
      cyc();
      #2 rst_n = 1'b1;
   endtask

   initial begin
      int g_cnt;
      int t_cnt;
      int te_with_grant;

      //           en    tk    rq       dn       g        cr     dr      te
      vt[0]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'd0, 16'd0, 1'b0};
      vt[1]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'd0, 16'd0, 1'b0};
      vt[2]  = '{1'b1, 1'b1, 4'b0001, 4'b0000, 4'b0001, 4'd0, 16'd0, 1'b0};
      vt[3]  = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0001, 4'd0, 16'd0, 1'b0};
      vt[4]  = '{1'b1, 1'b0, 4'b0000, 4'b0000, 4'b0001, 4'd0, 16'd0, 1'b0};
      vt[5]  = '{1'b1, 1'b0, 4'b0000, 4'b0010, 4'b0001, 4'd0, 16'd0, 1'b0};
      vt[6]  = '{1'b1, 1'b0, 4'b0000, 4'b0001, 4'b0000, 4'd0, 16'd0, 1'b0};
      vt[7]  = '{1'b1, 1'b1, 4'b0000, 4'b0001, 4'b0000, 4'd1, 16'd0, 1'b0};
      vt[8]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'd2, 16'd0, 1'b0};
      vt[9]  = '{1'b0, 1'b1, 4'b1111, 4'b0000, 4'b0000, 4'd3, 16'd0, 1'b0};
      vt[10] = '{1'b1, 1'b1, 4'b1111, 4'b0000, 4'b0010, 4'd3, 16'd0, 1'b0};
      vt[11] = '{1'b1, 1'b0, 4'b1111, 4'b0010, 4'b0000, 4'd3, 16'd0, 1'b0};
      vt[12] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0100, 4'd2, 16'd0, 1'b0};
      vt[13] = '{1'b1, 1'b0, 4'b1111, 4'b0100, 4'b0000, 4'd2, 16'd0, 1'b0};
      vt[14] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4'b1000, 4'd1, 16'd0, 1'b0};
      vt[15] = '{1'b1, 1'b1, 4'b1111, 4'b0010, 4'b1000, 4'd2, 16'd0, 1'b0};
      vt[16] = '{1'b1, 1'b0, 4'b1111, 4'b1000, 4'b0000, 4'd2, 16'd0, 1'b0};
      vt[17] = '{1'b1, 1'b0, 4'b1111, 4'b0000, 4'b0001, 4'd1, 16'd0, 1'b0};
      vt[18] = '{1'b1, 1'b0, 4'b1111, 4'b0001, 4'b0000, 4'd1, 16'd0, 1'b0};
      vt[19] = '{1'b1, 1'b0, 4'b0100, 4'b0000, 4'b0100, 4'd0, 16'd0, 1'b0};
      vt[20] = '{1'b1, 1'b0, 4'b0100, 4'b0100, 4'b0000, 4'd0, 16'd0, 1'b0};
      vt[21] = '{1'b1, 1'b0, 4'b0001, 4'b0000, 4'b0000, 4'd0, 16'd0, 1'b0};

      // reset state
      do_reset();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_credits", 32'(credits), 32'd0);
      chk("rst_drop", 32'(drop_count), 32'd0);
      chk("rst_terr", 32'(timeout_err), 32'd0);

      // table-driven main function
      for (int i = 0; i < 22; i++) begin
         enable = vt[i].en; tick = vt[i].tk; req = vt[i].rq; done = vt[i].dn;
         cyc();
         chk($sformatf("v%0d_grant", i), 32'(grant), 32'(vt[i].g));
         chk($sformatf("v%0d_credits", i), 32'(credits), 32'(vt[i].cr));
         chk($sformatf("v%0d_drop", i), 32'(drop_count), 32'(vt[i].dr));
         chk($sformatf("v%0d_terr", i), 32'(timeout_err), 32'(vt[i].te));
      end

      // saturation: 10 ticks with no request
      do_reset();
      enable = 1'b1; req = '0; done = '0;
      for (int i = 0; i < 10; i++) begin
         tick = 1'b1;
         cyc();
      end
      tick = 1'b0;
      cyc();
      chk("sat_credits", 32'(credits), 32'd8);
      chk("sat_drop", 32'(drop_count), 32'd2);

      // timeout: port 2 granted, done never sent
      req = 4'b0100;
      cyc();
      req = '0;
      chk("to_grant_first", 32'(grant), 32'b0100);
      chk("to_credits_spent", 32'(credits), 32'd7);
      g_cnt = 1; t_cnt = 0; te_with_grant = 0;
      for (int i = 0; i < 30; i++) begin
         cyc();
         if (grant != '0) g_cnt++;
         if (timeout_err) begin
            t_cnt++;
            if (grant != '0) te_with_grant++;
         end
      end
      chk("to_grant_cycles", 32'(g_cnt), 32'd16);
      chk("to_terr_pulses", 32'(t_cnt), 32'd1);
      chk("to_terr_with_grant", 32'(te_with_grant), 32'd0);
      chk("to_credits_kept", 32'(credits), 32'd7);

      // done on the same edge the timeout would expire
      req = 4'b0100;
      cyc();
      req = '0;
      chk("dx_grant_first", 32'(grant), 32'b0100);
      for (int i = 0; i < 15; i++) cyc();
      chk("dx_grant_last", 32'(grant), 32'b0100);
      done = 4'b0100;
      cyc();
      done = '0;
      chk("dx_grant_rel", 32'(grant), 32'd0);
      chk("dx_terr", 32'(timeout_err), 32'd0);
      cyc();
      chk("dx_terr_next", 32'(timeout_err), 32'd0);
      chk("dx_credits", 32'(credits), 32'd6);

      // asynchronous reset mid-busy with credits=5
      req = 4'b0001;
      cyc();
      chk("ar_grant_before", 32'(grant), 32'b0001);
      chk("ar_credits_before", 32'(credits), 32'd5);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_grant", 32'(grant), 32'd0);
      chk("ar_credits", 32'(credits), 32'd0);
      chk("ar_drop", 32'(drop_count), 32'd0);
      chk("ar_terr", 32'(timeout_err), 32'd0);
      cyc();
      chk("ar_terr_hold", 32'(timeout_err), 32'd0);
      rst_n = 1'b1;
      // no credits, no tick: request must wait
      cyc();
      cyc();
      chk("ar_no_grant", 32'(grant), 32'd0);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      chk("ar_first_grant", 32'(grant), 32'b0001);
      chk("ar_first_credits", 32'(credits), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
